alu_op_sequencer: RTL and testbench

- Parametrised control sequencer for the Mini SRC datapath.
- Generates the per-phase control strobes for a full instruction cycle: fetch (T0–T2), then execute.
- Covers three-register ALU ops (T3–T5) and two-result MUL/DIV ops (T3–T6).
- Replaces hand-sequenced control; drives the datapath's register select and strobe inputs directly.

---
 rtl/alu_op_sequencer.sv | 214 +++++++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// Mini SRC control sequencer: fetch (T0-T2) then ALU (T3-T5) or MUL/DIV (T3-T6) execute.
// Optional macro ALU_SEQ_MEM_WAIT_EN stretches T1 until mem_ready is seen high.
module alu_op_sequencer #(
  parameter int NUM_REGS   = 16,
  parameter int ALU_OP_MAX = 14,
  parameter int OPC_MUL    = 15,
  parameter int OPC_DIV    = 16
) (
  input  logic                clock,
  input  logic                clear,
  input  logic                start,
  input  logic [31:0]         ir,
  input  logic                mem_ready,
  output logic                PCout,
  output logic                MARin,
  output logic                IncPC,
  output logic                Zin,
  output logic                Zlowout,
  output logic                Zhighout,
  output logic                PCin,
  output logic                Read,
  output logic                MDRin,
  output logic                MDRout,
  output logic                IRin,
  output logic                Yin,
  output logic                LOin,
  output logic                HIin,
  output logic [NUM_REGS-1:0] reg_out_sel,
  output logic [NUM_REGS-1:0] reg_in_sel,
  output logic [4:0]          alu_op,
  output logic                busy,
  output logic                done,
  output logic                illegal
);

  typedef enum logic [2:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6
  } state_t;

  typedef struct packed {
    logic                pc_out;
    logic                mar_in;
    logic                inc_pc;
    logic                z_in;
    logic                zlow_out;
    logic                zhigh_out;
    logic                pc_in;
    logic                read;
    logic                mdr_in;
    logic                mdr_out;
    logic                ir_in;
    logic                y_in;
    logic                lo_in;
    logic                hi_in;
    logic [NUM_REGS-1:0] reg_out_sel;
    logic [NUM_REGS-1:0] reg_in_sel;
    logic [4:0]          alu_op;
    logic                busy;
    logic                done;
    logic                illegal;
  } ctl_t;

  state_t              state, state_next;
  ctl_t                ctl_reg, ctl_next;
  logic [4:0]          op_reg;
  logic [NUM_REGS-1:0] ra_hot_reg, rc_hot_reg;
  logic                muldiv_reg, bad_reg;

  logic [4:0]          ir_op;
  logic [3:0]          ir_ra, ir_rb, ir_rc;
  logic [NUM_REGS-1:0] ra_hot, rb_hot, rc_hot;
  logic                dec_alu, dec_muldiv, dec_bad;
  logic                unused_bits;

  assign ir_op = ir[31:27];
  assign ir_ra = ir[26:23];
  assign ir_rb = ir[22:19];
  assign ir_rc = ir[18:15];

  // A field naming a register that does not exist decodes to an all-zero select.
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_hot
    assign ra_hot[gi] = (ir_ra == 4'(gi));
    assign rb_hot[gi] = (ir_rb == 4'(gi));
    assign rc_hot[gi] = (ir_rc == 4'(gi));
  end

  assign dec_alu    = (ir_op <= 5'(ALU_OP_MAX));
  assign dec_muldiv = (ir_op == 5'(OPC_MUL)) || (ir_op == 5'(OPC_DIV));
  assign dec_bad    = !(dec_alu || dec_muldiv) || !(|rb_hot) || !(|rc_hot) ||
                      (dec_alu && !(|ra_hot));

`ifdef ALU_SEQ_MEM_WAIT_EN
  assign unused_bits = ^ir[14:0];
`else
  assign unused_bits = ^{ir[14:0], mem_ready};
`endif

  always_comb begin
    state_next = state;
    ctl_next   = '0;

    case (state)
      S_IDLE: if (start) state_next = S_T0;
      S_T0:   state_next = S_T1;
`ifdef ALU_SEQ_MEM_WAIT_EN
      S_T1:   state_next = mem_ready ? S_T2 : S_T1;
`else
      S_T1:   state_next = S_T2;
`endif
      S_T2:   state_next = S_T3;
      S_T3:   state_next = bad_reg ? S_IDLE : S_T4;
      S_T4:   state_next = S_T5;
      S_T5:   state_next = muldiv_reg ? S_T6 : S_IDLE;
      S_T6:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase

    // Outputs follow the state being entered so they line up with that state's cycle.
    case (state_next)
      S_T0: begin
        ctl_next.pc_out = 1'b1;
        ctl_next.mar_in = 1'b1;
        ctl_next.inc_pc = 1'b1;
        ctl_next.z_in   = 1'b1;
        ctl_next.busy   = 1'b1;
      end
      S_T1: begin
        ctl_next.zlow_out = 1'b1;
        ctl_next.pc_in    = 1'b1;
        ctl_next.read     = 1'b1;
        ctl_next.mdr_in   = 1'b1;
        ctl_next.busy     = 1'b1;
      end
      S_T2: begin
        ctl_next.mdr_out = 1'b1;
        ctl_next.ir_in   = 1'b1;
        ctl_next.busy    = 1'b1;
      end
      S_T3: begin
        // T3 is only entered from T2, so the live IR decode is the one that applies.
        ctl_next.busy = 1'b1;
        if (!dec_bad) begin
          ctl_next.reg_out_sel = rb_hot;
          ctl_next.y_in        = 1'b1;
        end
      end
      S_T4: begin
        ctl_next.reg_out_sel = rc_hot_reg;
        ctl_next.alu_op      = op_reg;
        ctl_next.z_in        = 1'b1;
        ctl_next.busy        = 1'b1;
      end
      S_T5: begin
        ctl_next.zlow_out = 1'b1;
        ctl_next.busy     = 1'b1;
        if (muldiv_reg) ctl_next.lo_in      = 1'b1;
        else            ctl_next.reg_in_sel = ra_hot_reg;
      end
      S_T6: begin
        ctl_next.zhigh_out = 1'b1;
        ctl_next.hi_in     = 1'b1;
        ctl_next.busy      = 1'b1;
      end
      default: begin
        ctl_next.done    = (state != S_IDLE);
        ctl_next.illegal = (state == S_T3);
      end
    endcase
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state      <= S_IDLE;
      ctl_reg    <= '0;
      op_reg     <= '0;
      ra_hot_reg <= '0;
      rc_hot_reg <= '0;
      muldiv_reg <= 1'b0;
      bad_reg    <= 1'b0;
    end else begin
      state   <= state_next;
      ctl_reg <= ctl_next;
      if (state == S_T2) begin
        op_reg     <= ir_op;
        ra_hot_reg <= ra_hot;
        rc_hot_reg <= rc_hot;
        muldiv_reg <= dec_muldiv;
        bad_reg    <= dec_bad;
      end
    end
  end

  assign PCout       = ctl_reg.pc_out;
  assign MARin       = ctl_reg.mar_in;
  assign IncPC       = ctl_reg.inc_pc;
  assign Zin         = ctl_reg.z_in;
  assign Zlowout     = ctl_reg.zlow_out;
  assign Zhighout    = ctl_reg.zhigh_out;
  assign PCin        = ctl_reg.pc_in;
  assign Read        = ctl_reg.read;
  assign MDRin       = ctl_reg.mdr_in;
  assign MDRout      = ctl_reg.mdr_out;
  assign IRin        = ctl_reg.ir_in;
  assign Yin         = ctl_reg.y_in;
  assign LOin        = ctl_reg.lo_in;
  assign HIin        = ctl_reg.hi_in;
  assign reg_out_sel = ctl_reg.reg_out_sel;
  assign reg_in_sel  = ctl_reg.reg_in_sel;
  assign alu_op      = ctl_reg.alu_op;
  assign busy        = ctl_reg.busy;
  assign done        = ctl_reg.done;
  assign illegal     = ctl_reg.illegal;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: a 16-register and an 8-register instance run in lockstep
// against a queue-based reference of expected per-cycle outputs.
module tb_alu_op_sequencer;

`ifdef ALU_SEQ_MEM_WAIT_EN
  localparam bit MEMWAIT = 1'b1;
`else
  localparam bit MEMWAIT = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        clear, start, mem_ready;
  logic [31:0] ir;

  // strobe bit order: PCout MARin IncPC Zin Zlowout Zhighout PCin Read MDRin MDRout IRin Yin LOin HIin
  wire [13:0] a_stb, b_stb;
  wire [15:0] a_ro, a_ri;
  wire [7:0]  b_ro, b_ri;
  wire [4:0]  a_op, b_op;
  wire        a_busy, a_done, a_ill, b_busy, b_done, b_ill;

  always #5 clock = ~clock;

  alu_op_sequencer #(.NUM_REGS(16)) dut_a (
    .clock(clock), .clear(clear), .start(start), .ir(ir), .mem_ready(mem_ready),
    .PCout(a_stb[13]), .MARin(a_stb[12]), .IncPC(a_stb[11]), .Zin(a_stb[10]),
    .Zlowout(a_stb[9]), .Zhighout(a_stb[8]), .PCin(a_stb[7]), .Read(a_stb[6]),
    .MDRin(a_stb[5]), .MDRout(a_stb[4]), .IRin(a_stb[3]), .Yin(a_stb[2]),
    .LOin(a_stb[1]), .HIin(a_stb[0]),
    .reg_out_sel(a_ro), .reg_in_sel(a_ri), .alu_op(a_op),
    .busy(a_busy), .done(a_done), .illegal(a_ill)
  );

  alu_op_sequencer #(.NUM_REGS(8)) dut_b (
    .clock(clock), .clear(clear), .start(start), .ir(ir), .mem_ready(mem_ready),
    .PCout(b_stb[13]), .MARin(b_stb[12]), .IncPC(b_stb[11]), .Zin(b_stb[10]),
    .Zlowout(b_stb[9]), .Zhighout(b_stb[8]), .PCin(b_stb[7]), .Read(b_stb[6]),
    .MDRin(b_stb[5]), .MDRout(b_stb[4]), .IRin(b_stb[3]), .Yin(b_stb[2]),
    .LOin(b_stb[1]), .HIin(b_stb[0]),
    .reg_out_sel(b_ro), .reg_in_sel(b_ri), .alu_op(b_op),
    .busy(b_busy), .done(b_done), .illegal(b_ill)
  );

  typedef struct packed {
    logic [13:0] stb;
    logic [15:0] ro;
    logic [15:0] ri;
    logic [4:0]  op;
    logic        busy;
    logic        done;
    logic        ill;
  } obs_t;

  typedef struct {
    obs_t o;
    bit   t1;
  } item_t;

  typedef item_t iq_t[$];

  typedef struct {
    logic [31:0] ir;
    int          lat;
    bit          ill;
    logic [15:0] ro;
    logic [15:0] ri;
    logic [4:0]  op;
    int          lat8;
    bit          ill8;
  } vec_t;

  localparam logic [13:0] M_T0   = 14'b1111_0000_0000_00;
  localparam logic [13:0] M_T1   = 14'b0000_1011_1000_00;
  localparam logic [13:0] M_T2   = 14'b0000_0000_0110_00;
  localparam logic [13:0] M_T3   = 14'b0000_0000_0001_00;
  localparam logic [13:0] M_T4   = 14'b0001_0000_0000_00;
  localparam logic [13:0] M_T5A  = 14'b0000_1000_0000_00;
  localparam logic [13:0] M_T5M  = 14'b0000_1000_0000_10;
  localparam logic [13:0] M_T6   = 14'b0000_0100_0000_01;
  localparam logic [31:0] IR_ADD = 32'h1A98_0000;

  int  tests = 0;
  int  fails = 0;
  int  cyc   = 0;
  iq_t qa, qb;

  function automatic obs_t obs_a();
    return {a_stb, a_ro, a_ri, a_op, a_busy, a_done, a_ill};
  endfunction

  function automatic obs_t obs_b();
    return {b_stb, 8'h00, b_ro, 8'h00, b_ri, b_op, b_busy, b_done, b_ill};
  endfunction

  function automatic item_t mk(logic [13:0] s, logic [15:0] ro, logic [15:0] ri,
                               logic [4:0] op, bit bz, bit dn, bit il, bit t1);
    item_t it;
    it.o  = {s, ro, ri, op, bz, dn, il};
    it.t1 = t1;
    return it;
  endfunction

  // Whole expected instruction as a list of cycles, straight from the instruction's rules.
  function automatic iq_t build(logic [31:0] i, int n);
    iq_t q;
    int  op = int'(i[31:27]);
    int  ra = int'(i[26:23]);
    int  rb = int'(i[22:19]);
    int  rc = int'(i[18:15]);
    bit  alu = (op <= 14);
    bit  md  = (op == 15) || (op == 16);
    bit  bad = !(alu || md) || (rb >= n) || (rc >= n) || (alu && ra >= n);
    q.push_back(mk(M_T0, '0, '0, '0, 1, 0, 0, 0));
    q.push_back(mk(M_T1, '0, '0, '0, 1, 0, 0, 1));
    q.push_back(mk(M_T2, '0, '0, '0, 1, 0, 0, 0));
    if (bad) begin
      q.push_back(mk('0, '0, '0, '0, 1, 0, 0, 0));
      q.push_back(mk('0, '0, '0, '0, 0, 1, 1, 0));
    end else begin
      q.push_back(mk(M_T3, 16'(1) << rb, '0, '0, 1, 0, 0, 0));
      q.push_back(mk(M_T4, 16'(1) << rc, '0, 5'(op), 1, 0, 0, 0));
      if (alu) begin
        q.push_back(mk(M_T5A, '0, 16'(1) << ra, '0, 1, 0, 0, 0));
      end else begin
        q.push_back(mk(M_T5M, '0, '0, '0, 1, 0, 0, 0));
        q.push_back(mk(M_T6, '0, '0, '0, 1, 0, 0, 0));
      end
      q.push_back(mk('0, '0, '0, '0, 0, 1, 0, 0));
    end
    return q;
  endfunction

  function automatic iq_t adv(iq_t q, int n);
    iq_t r = q;
    if (r.size() == 0 || !r[0].o.busy) begin
      r.delete();
      if (start) r = build(ir, n);
    end else if (!(MEMWAIT && r[0].t1 && !mem_ready)) begin
      void'(r.pop_front());
    end
    return r;
  endfunction

  task automatic cmp(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic cmp_obs(input string name, input obs_t got, input obs_t exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, got, exp);
    end
  endtask

  task automatic step();
    obs_t ea, eb;
    @(posedge clock);
    cyc++;
    if (!clear) begin
      qa.delete();
      qb.delete();
    end else begin
      qa = adv(qa, 16);
      qb = adv(qb, 8);
    end
    @(negedge clock);
    ea = (qa.size() != 0) ? qa[0].o : '0;
    eb = (qb.size() != 0) ? qb[0].o : '0;
    cmp_obs("dut16_outputs", obs_a(), ea);
    cmp_obs("dut8_outputs", obs_b(), eb);
  endtask

  task automatic run_instr(input logic [31:0] i, output int lat_a, output int lat_b,
                           output bit ill_a, output bit ill_b, output logic [15:0] ro_or,
                           output logic [15:0] ri_or, output logic [4:0] op_or);
    obs_t oa, ob;
    lat_a = 0; lat_b = 0; ill_a = 0; ill_b = 0;
    ro_or = '0; ri_or = '0; op_or = '0;
    ir    = i;
    start = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      step();
      start = 1'b0;
      oa = obs_a();
      ob = obs_b();
      ro_or |= oa.ro;
      ri_or |= oa.ri;
      op_or |= oa.op;
      if (oa.done && lat_a == 0) begin lat_a = k; ill_a = oa.ill; end
      if (ob.done && lat_b == 0) begin lat_b = k; ill_b = ob.ill; end
      if (lat_a != 0 && lat_b != 0) break;
    end
  endtask

  initial begin
    vec_t        vt[8];
    int          la, lb, dn, rd, lat;
    bit          ia, ib;
    logic [15:0] ro_or, ri_or;
    logic [4:0]  op_or, op;
    logic [31:0] r;
    bit          finished;

    vt[0] = '{32'h1A98_0000, 7, 0, 16'h0009, 16'h0020, 5'd3,  7, 0};
    vt[1] = '{32'h7812_0000, 8, 0, 16'h0014, 16'h0000, 5'd15, 8, 0};
    vt[2] = '{32'h83F8_8000, 8, 0, 16'h8002, 16'h0000, 5'd16, 5, 1};
    vt[3] = '{32'hF800_0000, 5, 1, 16'h0000, 16'h0000, 5'd0,  5, 1};
    vt[4] = '{32'h77FF_8000, 7, 0, 16'h8000, 16'h8000, 5'd14, 5, 1};
    vt[5] = '{32'h0009_0000, 7, 0, 16'h0006, 16'h0001, 5'd0,  7, 0};
    vt[6] = '{32'h8800_0000, 5, 1, 16'h0000, 16'h0000, 5'd0,  5, 1};
    vt[7] = '{32'h1C89_0000, 7, 0, 16'h0006, 16'h0200, 5'd3,  5, 1};

    clear = 1'b1; start = 1'b0; mem_ready = 1'b1; ir = '0;
    #1 clear = 1'b0;
    #1;
    cmp_obs("reset_dut16", obs_a(), '0);
    cmp_obs("reset_dut8", obs_b(), '0);
    step();
    step();
    clear = 1'b1;
    step();

    // table of single instructions, memory always ready
    for (int t = 0; t < 8; t++) begin
      run_instr(vt[t].ir, la, lb, ia, ib, ro_or, ri_or, op_or);
      cmp($sformatf("vec%0d_latency", t), la, vt[t].lat);
      cmp($sformatf("vec%0d_illegal", t), int'(ia), int'(vt[t].ill));
      cmp($sformatf("vec%0d_reg_out_or", t), int'(ro_or), int'(vt[t].ro));
      cmp($sformatf("vec%0d_reg_in_or", t), int'(ri_or), int'(vt[t].ri));
      cmp($sformatf("vec%0d_alu_op", t), int'(op_or), int'(vt[t].op));
      cmp($sformatf("vec%0d_latency_r8", t), lb, vt[t].lat8);
      cmp($sformatf("vec%0d_illegal_r8", t), int'(ib), int'(vt[t].ill8));
    end
    step();

    // start held high: one done-carrying IDLE cycle between back-to-back instructions
    ir = IR_ADD;
    start = 1'b1;
    dn = 0;
    for (int k = 1; k <= 16; k++) begin
      step();
      if (a_done) dn++;
    end
    start = 1'b0;
    cmp("held_start_done_count", dn, 2);
    for (int k = 0; k < 10; k++) step();

    // clear pulsed during T4: everything drops at once, no T5 write afterwards
    ir = IR_ADD;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 2; k <= 5; k++) step();
    cmp("midop_t4_alu_op", int'(a_op), 3);
    clear = 1'b0;
    #1;
    cmp_obs("midop_async_dut16", obs_a(), '0);
    cmp_obs("midop_async_dut8", obs_b(), '0);
    qa.delete();
    qb.delete();
    step();
    step();
    clear = 1'b1;
    ri_or = '0;
    for (int k = 0; k < 5; k++) begin
      step();
      ri_or |= a_ri;
    end
    cmp("midop_no_write", int'(ri_or), 0);

    // memory wait: mem_ready low at the first three T1 sampling edges
    ir = IR_ADD;
    mem_ready = 1'b0;
    start = 1'b1;
    lat = 0;
    rd = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      start = 1'b0;
      if (a_stb[6]) rd++;
      if (a_done && lat == 0) lat = k;
      if (k == 5) mem_ready = 1'b1;
    end
    cmp("memwait_latency", lat, MEMWAIT ? 10 : 7);
    cmp("memwait_read_cycles", rd, MEMWAIT ? 4 : 1);

    // random instructions with random memory readiness
    for (int n = 0; n < 60; n++) begin
      r  = $urandom();
      op = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 16));
      ir = {op, r[26:0]};
      start = 1'b1;
      finished = 1'b0;
      for (int k = 0; k < 40; k++) begin
        mem_ready = ($urandom_range(0, 3) != 0);
        step();
        start = 1'b0;
        if (qa.size() == 0 || !qa[0].o.busy) begin
          finished = 1'b1;
          break;
        end
      end
      if (!finished) begin
        tests++;
        fails++;
        $display("FAIL random_timeout: instruction %h did not complete within 40 cycles", ir);
      end
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) step();
    end
    mem_ready = 1'b1;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
